// File: rtl/pwm_fade_controller_pkg.sv
// Shared definitions for the LED PWM fade path: defaults, the FSM state
// encoding and a small helper for sizing the period-count registers.
package pwm_fade_controller_pkg;

    localparam int unsigned DEF_PERIOD       = 100;
    localparam int unsigned DEF_WIDTH        = 8;
    localparam int unsigned DEF_STEP         = 1;
    localparam int unsigned DEF_PRESCALE     = 4;
    localparam int unsigned DEF_HOLD_PERIODS = 16;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_HOLD_HIGH = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_HOLD_LOW  = 3'd4
    } fade_state_t;

    // Bits needed to count 0..n-1 (at least one bit)
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pwm_fade_controller_pwm_core.sv
// PWM period counter and compare stage.
//   clock      : system clock, rising edge
//   reset      : asynchronous active-high reset
//   run        : 1 = count; 0 = hold the counter at 0
//   duty       : number of high cycles per period (0..PERIOD)
//   led        : PWM output, high while counter < duty
//   period_end : high in the last cycle of every running period
module pwm_core
    import pwm_fade_controller_pkg::*;
#(
    parameter int unsigned PERIOD = DEF_PERIOD,
    parameter int unsigned WIDTH  = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             run,
    input  logic [WIDTH-1:0] duty,
    output logic             led,
    output logic             period_end
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(PERIOD - 1);

    logic [WIDTH-1:0] counter;

    // Period counter; cleared whenever the sequencer is not running
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            counter <= '0;
        end else if (!run || (counter == LAST)) begin
            counter <= '0;
        end else begin
            counter <= counter + WIDTH'(1);
        end
    end

    // Compare straight off the counter/duty registers so duty=0 and
    // duty=PERIOD give a constant level with no edge
    assign led        = (counter < duty);
    assign period_end = run && (counter == LAST);

endmodule

// File: rtl/pwm_fade_controller.sv
// Breathing sequencer for the LED PWM path: ramps duty up to a latched
// ceiling, holds, ramps down to zero, holds, and repeats. All duty and
// state changes happen on the period_end edge, so a new duty takes effect
// exactly when the PWM counter wraps to 0.
//   clock      : system clock, rising edge
//   reset      : asynchronous active-high reset
//   enable     : 1 = run the fade sequence; 0 = return to IDLE
//   duty_max   : ramp ceiling, latched entering RAMP_UP, clamped to PERIOD
//   led        : PWM output
//   duty       : duty currently applied by the compare stage
//   period_end : one-cycle pulse in the last cycle of each period
//   state      : FSM state (IDLE=0 .. HOLD_LOW=4)
//   busy       : high whenever state is not IDLE
module pwm_fade_controller
    import pwm_fade_controller_pkg::*;
#(
    parameter int unsigned PERIOD       = DEF_PERIOD,
    parameter int unsigned WIDTH        = DEF_WIDTH,
    parameter int unsigned STEP         = DEF_STEP,
    parameter int unsigned PRESCALE     = DEF_PRESCALE,
    parameter int unsigned HOLD_PERIODS = DEF_HOLD_PERIODS
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic [WIDTH-1:0]   duty_max,
    output logic               led,
    output logic [WIDTH-1:0]   duty,
    output logic               period_end,
    output logic [STATE_W-1:0] state,
    output logic               busy
);

    localparam int unsigned PS_W   = cnt_width(PRESCALE);
    localparam int unsigned HOLD_W = cnt_width(HOLD_PERIODS);
    localparam int unsigned WP1    = WIDTH + 1;

    localparam logic [WIDTH-1:0]  PERIOD_V  = WIDTH'(PERIOD);
    localparam logic [WP1-1:0]    STEP_V    = WP1'(STEP);
    localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(PRESCALE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_PERIODS - 1);

    fade_state_t       state_q, state_d;
    logic [WIDTH-1:0]  duty_q, duty_d;
    logic [WIDTH-1:0]  limit_q, limit_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              busy_q;

    logic              run;
    logic              pe;
    logic [WIDTH-1:0]  latch_val;
    logic [WP1-1:0]    up_sum;
    logic [WIDTH-1:0]  duty_up;
    logic [WIDTH-1:0]  duty_dn;

    // Counter runs only while sequencing; dropping enable clears it on the
    // same edge that returns the FSM to IDLE
    assign run = (state_q != ST_IDLE) && enable;

    pwm_core #(
        .PERIOD (PERIOD),
        .WIDTH  (WIDTH)
    ) u_pwm_core (
        .clock      (clock),
        .reset      (reset),
        .run        (run),
        .duty       (duty_q),
        .led        (led),
        .period_end (pe)
    );

    // Ceiling clamp and saturating step arithmetic, one bit wider so
    // neither direction can wrap
    always_comb begin
        latch_val = (duty_max > PERIOD_V) ? PERIOD_V : duty_max;
        up_sum    = {1'b0, duty_q} + STEP_V;
        duty_up   = (up_sum > {1'b0, limit_q}) ? limit_q : up_sum[WIDTH-1:0];
        duty_dn   = ({1'b0, duty_q} > STEP_V) ? WIDTH'({1'b0, duty_q} - STEP_V) : '0;
    end

    // State and datapath registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            duty_q  <= '0;
            limit_q <= '0;
            ps_q    <= '0;
            hold_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            limit_q <= limit_d;
            ps_q    <= ps_d;
            hold_q  <= hold_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Next-state and datapath update; everything but the IDLE exit waits
    // for period_end
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        limit_d = limit_q;
        ps_d    = ps_q;
        hold_d  = hold_q;

        if (!enable) begin
            state_d = ST_IDLE;
            duty_d  = '0;
            limit_d = '0;
            ps_d    = '0;
            hold_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_RAMP_UP;
                    limit_d = latch_val;
                    duty_d  = '0;
                    ps_d    = '0;
                    hold_d  = '0;
                end
                ST_RAMP_UP: begin
                    if (pe) begin
                        if (ps_q == PS_LAST) begin
                            ps_d   = '0;
                            duty_d = duty_up;
                            if (duty_up == limit_q) begin
                                state_d = ST_HOLD_HIGH;
                                hold_d  = '0;
                            end
                        end else begin
                            ps_d = ps_q + PS_W'(1);
                        end
                    end
                end
                ST_HOLD_HIGH: begin
                    if (pe) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = ST_RAMP_DOWN;
                            ps_d    = '0;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                ST_RAMP_DOWN: begin
                    if (pe) begin
                        if (ps_q == PS_LAST) begin
                            ps_d   = '0;
                            duty_d = duty_dn;
                            if (duty_dn == '0) begin
                                state_d = ST_HOLD_LOW;
                                hold_d  = '0;
                            end
                        end else begin
                            ps_d = ps_q + PS_W'(1);
                        end
                    end
                end
                ST_HOLD_LOW: begin
                    if (pe) begin
                        if (hold_q == HOLD_LAST) begin
                            state_d = ST_RAMP_UP;
                            limit_d = latch_val;
                            ps_d    = '0;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    duty_d  = '0;
                    limit_d = '0;
                    ps_d    = '0;
                    hold_d  = '0;
                end
            endcase
        end
    end

    assign duty       = duty_q;
    assign state      = state_q;
    assign busy       = busy_q;
    assign period_end = pe;

endmodule

// File: tb/tb_pwm_fade_controller.sv
// Self-checking bench for pwm_fade_controller with a scoreboard fed by an
// independent cycle model, plus fixed timeline and boundary checks.
module tb_pwm_fade_controller;

    localparam int P    = 10;
    localparam int W    = 8;
    localparam int STP  = 3;
    localparam int PS   = 2;
    localparam int HOLD = 2;

    logic         clock;
    logic         reset;
    logic         enable;
    logic [W-1:0] duty_max;
    logic         led;
    logic [W-1:0] duty;
    logic         period_end;
    logic [2:0]   state;
    logic         busy;

    pwm_fade_controller #(
        .PERIOD       (P),
        .WIDTH        (W),
        .STEP         (STP),
        .PRESCALE     (PS),
        .HOLD_PERIODS (HOLD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .duty_max   (duty_max),
        .led        (led),
        .duty       (duty),
        .period_end (period_end),
        .state      (state),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [2:0]   st;
        logic [W-1:0] du;
        logic         ld;
        logic         pe;
        logic         bz;
    } obs_t;

    obs_t exp_q[$];

    int checks = 0;
    int errors = 0;

    // model state
    int m_state, m_cnt, m_duty, m_limit, m_ps, m_hold;

    // bookkeeping
    int ones;
    int led_total;
    bit rec;
    int cyc;
    int obs_st[260];
    int obs_du[260];

    // fixed timeline of the full-cycle run: cycle, kind (0=state 1=duty), value
    int tl_cyc [20] = '{0, 0, 19, 20, 39, 40, 60, 79, 80, 80, 99, 100, 120, 140, 160, 179, 180, 180, 199, 200};
    int tl_kind[20] = '{0, 1, 1,  1,  1,  1,  1,  0,  0,  1,  0,  0,   1,   1,   1,   0,   0,   1,   0,   0};
    int tl_val [20] = '{1, 0, 0,  3,  3,  6,  9,  1,  2,  10, 2,  3,   7,   4,   1,   3,   4,   0,   4,   1};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_state = 0; m_cnt = 0; m_duty = 0; m_limit = 0; m_ps = 0; m_hold = 0;
    endtask

    // Advance the model across one rising edge using the current inputs
    task automatic model_update();
        bit wrap;
        if (reset || !enable) begin
            model_clear();
        end else if (m_state == 0) begin
            m_state = 1;
            m_limit = (int'(duty_max) > P) ? P : int'(duty_max);
            m_cnt = 0; m_duty = 0; m_ps = 0; m_hold = 0;
        end else begin
            wrap  = (m_cnt == P - 1);
            m_cnt = wrap ? 0 : m_cnt + 1;
            if (wrap) begin
                case (m_state)
                    1: begin
                        m_ps++;
                        if (m_ps == PS) begin
                            m_ps = 0;
                            m_duty = (m_duty + STP > m_limit) ? m_limit : m_duty + STP;
                            if (m_duty == m_limit) begin m_state = 2; m_hold = 0; end
                        end
                    end
                    2: begin
                        m_hold++;
                        if (m_hold == HOLD) begin m_state = 3; m_ps = 0; m_hold = 0; end
                    end
                    3: begin
                        m_ps++;
                        if (m_ps == PS) begin
                            m_ps = 0;
                            m_duty = (m_duty - STP < 0) ? 0 : m_duty - STP;
                            if (m_duty == 0) begin m_state = 4; m_hold = 0; end
                        end
                    end
                    default: begin
                        m_hold++;
                        if (m_hold == HOLD) begin
                            m_state = 1; m_ps = 0; m_hold = 0;
                            m_limit = (int'(duty_max) > P) ? P : int'(duty_max);
                        end
                    end
                endcase
            end
        end
    endtask

    // One clock: predict, push, clock, sample, pop and compare
    task automatic tick();
        obs_t e;
        obs_t g;
        model_update();
        e.st = 3'(m_state);
        e.du = W'(m_duty);
        e.ld = (m_cnt < m_duty);
        e.pe = (m_state != 0) && enable && (m_cnt == P - 1);
        e.bz = (m_state != 0);
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        g.st = state; g.du = duty; g.ld = led; g.pe = period_end; g.bz = busy;
        e = exp_q.pop_front();
        check("state", 32'(g.st), 32'(e.st));
        check("duty", 32'(g.du), 32'(e.du));
        check("led", 32'(g.ld), 32'(e.ld));
        check("period_end", 32'(g.pe), 32'(e.pe));
        check("busy", 32'(g.bz), 32'(e.bz));
        if (g.ld === 1'b1) led_total++;
        if (m_state != 0) begin
            if (g.ld === 1'b1) ones++;
            if (m_cnt == P - 1) begin
                check("led_ones_per_period", 32'(ones), 32'(m_duty));
                ones = 0;
            end
        end else begin
            ones = 0;
        end
        if (rec && cyc < 260) begin
            obs_st[cyc] = int'(state);
            obs_du[cyc] = int'(duty);
        end
        cyc++;
    endtask

    // Tick until the DUT reports the target state, bounded
    task automatic run_until(input int st, input int budget, input string tag);
        int n;
        n = 0;
        while (int'(state) != st && n < budget) begin
            tick();
            n++;
        end
        check(tag, 32'(state), 32'(st));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; duty_max = '0;
        model_clear();
        ones = 0; led_total = 0; rec = 1'b0; cyc = 0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_state", 32'(state), 0);
        check("rst_duty", 32'(duty), 0);
        check("rst_led", 32'(led), 0);
        check("rst_period_end", 32'(period_end), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b0;
        tick();
        tick();

        // full breathing cycle with a fixed timeline
        duty_max = W'(10); enable = 1'b1; rec = 1'b1; cyc = 0;
        repeat (230) tick();
        rec = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tl_kind[i] == 0)
                check($sformatf("timeline_state_c%0d", tl_cyc[i]), 32'(obs_st[tl_cyc[i]]), 32'(tl_val[i]));
            else
                check($sformatf("timeline_duty_c%0d", tl_cyc[i]), 32'(obs_du[tl_cyc[i]]), 32'(tl_val[i]));
        end

        // asynchronous reset in RAMP_UP with duty 6
        begin
            int n;
            n = 0;
            while (int'(duty) != 6 && n < 100) begin tick(); n++; end
            check("reach_duty6", 32'(duty), 6);
        end
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        check("midrst_led", 32'(led), 0);
        check("midrst_duty", 32'(duty), 0);
        check("midrst_state", 32'(state), 0);
        check("midrst_busy", 32'(busy), 0);
        model_clear();
        tick();
        reset = 1'b0;
        repeat (45) tick();

        // abort from HOLD_HIGH
        run_until(2, 200, "reach_hold_high");
        repeat (3) tick();
        enable = 1'b0;
        tick();
        check("abort_state", 32'(state), 0);
        check("abort_led", 32'(led), 0);
        tick();

        // clamp: duty_max above PERIOD peaks at PERIOD
        duty_max = W'(200); enable = 1'b1;
        run_until(2, 200, "clamp_reach_hold_high");
        check("clamp_peak", 32'(duty), 10);
        repeat (12) tick();

        // relatch: change in RAMP_DOWN only shows on the next sweep
        run_until(3, 200, "relatch_reach_ramp_down");
        duty_max = W'(5);
        run_until(4, 300, "relatch_reach_hold_low");
        run_until(1, 100, "relatch_reach_ramp_up");
        run_until(2, 300, "relatch_reach_hold_high");
        check("relatch_peak", 32'(duty), 5);

        // zero ceiling: whole sequence with led held low
        enable = 1'b0;
        tick();
        duty_max = '0; enable = 1'b1; led_total = 0;
        run_until(2, 100, "zero_reach_hold_high");
        check("zero_duty_hold_high", 32'(duty), 0);
        run_until(3, 100, "zero_reach_ramp_down");
        run_until(4, 100, "zero_reach_hold_low");
        run_until(1, 100, "zero_reach_ramp_up");
        check("zero_led_total", 32'(led_total), 0);

        enable = 1'b0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
